// File: rtl/wave_sequencer.sv
// Wave-table sequencer: paces reads from a 128-entry sample table with a prescaler,
// steps through it in bursts of whole periods and hands the samples on with a valid/ready handshake.
module wave_sequencer #(
    parameter int PRESC_W = 16,
    parameter int BURST_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PRESC_W-1:0]        i_prescaler,
    input  logic [6:0]                i_step,
    input  logic [BURST_W-1:0]        i_burst,
    input  logic                      i_start,
    input  logic                      i_stop,
    output logic                      o_ren,
    output logic [6:0]                o7_addr,
    input  logic signed [15:0]        is16_rdata,
    output logic signed [15:0]        os16_sample,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_overrun
);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t             state;
    logic [PRESC_W-1:0] presc_cnt;
    logic [6:0]         addr;
    logic [BURST_W-1:0] period_cnt;
    logic               rd_vld_p1;

    logic               tick;
    logic               pending;
    logic [7:0]         addr_sum;
    logic               wrap;
    logic               burst_end;

    function automatic logic [6:0] eff_step(input logic [6:0] step);
        return (step == 7'd0) ? 7'd1 : step;
    endfunction

    // Using >= lets a prescaler shrunk mid-count tick straight away instead of running to wrap.
    assign tick      = (state == RUN) && (presc_cnt >= i_prescaler);
    assign pending   = o_valid && !i_ready;
    assign o_ren     = tick && !pending && !i_stop;
    assign o7_addr   = addr;
    assign addr_sum  = {1'b0, addr} + {1'b0, eff_step(i_step)};
    assign wrap      = addr_sum[7];
    assign burst_end = wrap && (i_burst != '0) && ((period_cnt + BURST_W'(1)) == i_burst);
    assign o_busy    = (state != IDLE);
    // Done fires as the last sample leaves, so it does not wait an extra cycle for o_valid to drop.
    assign o_done    = (state == FINISH) && !rd_vld_p1 && (!o_valid || i_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            presc_cnt   <= '0;
            addr        <= '0;
            period_cnt  <= '0;
            rd_vld_p1   <= 1'b0;
            os16_sample <= '0;
            o_valid     <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        addr       <= '0;
                        period_cnt <= '0;
                        presc_cnt  <= '0;
                        o_overrun  <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (i_stop) begin
                        state <= FINISH;
                    end else begin
                        presc_cnt <= tick ? '0 : presc_cnt + PRESC_W'(1);
                        if (tick) begin
                            if (pending) begin
                                o_overrun <= 1'b1;
                            end else begin
                                addr <= addr_sum[6:0];
                                if (wrap)
                                    period_cnt <= period_cnt + BURST_W'(1);
                                if (burst_end)
                                    state <= FINISH;
                            end
                        end
                    end
                end
                FINISH: begin
                    if (o_done)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // stage p1: table data returns one cycle after the read
            rd_vld_p1 <= o_ren;
            if (rd_vld_p1) begin
                // A held sample is never overwritten; data arriving behind it is lost.
                if (!pending) begin
                    os16_sample <= is16_rdata;
                    o_valid     <= 1'b1;
                end else begin
                    o_overrun   <= 1'b1;
                end
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule
